ps2_kbd_ctrl: RTL and testbench

Keyboard-side controller sitting between the PS/2 byte decoder and the 68k bus. Assembles raw scan-code bytes into key events, tracking the 0xE0 extended and 0xF0 break prefixes, and queues the events in a small FIFO. Exposes the queue through a two-register CPU interface with a level interrupt. A prefix watchdog discards half-received sequences.

---
 rtl/ps2_kbd_ctrl_if.sv | 22 ++
 rtl/ps2_kbd_ctrl.sv | 144 ++++++++++++++
 tb/tb_ps2_kbd_ctrl.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/ps2_kbd_ctrl_if.sv
// Bundles the scan-code byte stream and the two-register CPU bus of the PS/2 keyboard controller.
// The master side is the decoder/CPU; the slave side is the controller.
interface ps2_kbd_ctrl_if;
   logic       rx_valid;
   logic [7:0] rx_data;
   logic       cs;
   logic       we;
   logic       addr;
   logic [7:0] wdata;
   logic [7:0] rdata;
   logic       irq;

   modport master (
      output rx_valid, rx_data, cs, we, addr, wdata,
      input  rdata, irq
   );

   modport slave (
      input  rx_valid, rx_data, cs, we, addr, wdata,
      output rdata, irq
   );
endinterface

// File: rtl/ps2_kbd_ctrl.sv
// Assembles PS/2 scan-code bytes into {ext, brk, code} events, queues them in a small FIFO
// and serves them to the CPU through DATA and STATUS/CTRL registers with a level interrupt.
module ps2_kbd_ctrl #(
   parameter int FIFO_DEPTH     = 4,
   parameter int TIMEOUT_CYCLES = 20000
) (
   input logic           clk,
   input logic           reset,
   ps2_kbd_ctrl_if.slave bus
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int WW = $clog2(TIMEOUT_CYCLES);

   typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_t;

   state_t        state;
   logic [WW-1:0] wd_cnt;

   logic [9:0]    mem [FIFO_DEPTH];
   logic [AW:0]   wr_ptr;
   logic [AW:0]   rd_ptr;
   logic          overflow;
   logic          irq_en;

   logic          is_e0, is_f0, is_prefix;
   logic          wd_fire;
   logic          push_req;
   logic [9:0]    push_ev;
   logic          empty, full;
   logic [9:0]    head;
   logic          data_rd, stat_rd, ctrl_wr, flush;
   logic          pop, do_push, ovf_set;
   logic [7:0]    status;
   logic          ctrl_unused;

   assign is_e0     = (bus.rx_data == 8'hE0);
   assign is_f0     = (bus.rx_data == 8'hF0);
   assign is_prefix = is_e0 | is_f0;

   // rx_valid clears the watchdog, so a byte arriving on the expiry cycle is still decoded.
   assign wd_fire  = (state != IDLE) && !bus.rx_valid && (wd_cnt == WW'(TIMEOUT_CYCLES - 1));

   // Every non-prefix byte completes an event; the current state supplies the flags.
   assign push_req = bus.rx_valid && !is_prefix;
   assign push_ev  = {(state == EXT) || (state == EXT_BRK),
                      (state == BRK) || (state == EXT_BRK),
                      bus.rx_data};

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state  <= IDLE;
         wd_cnt <= '0;
      end else if (bus.rx_valid) begin
         wd_cnt <= '0;
         case (state)
            IDLE: begin
               if (is_e0)
                  state <= EXT;
               else if (is_f0)
                  state <= BRK;
            end
            EXT: begin
               if (is_f0)
                  state <= EXT_BRK;
               else if (!is_e0)
                  state <= IDLE;
            end
            BRK, EXT_BRK: begin
               if (!is_prefix)
                  state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end else if (state == IDLE) begin
         wd_cnt <= '0;
      end else if (wd_fire) begin
         state  <= IDLE;
         wd_cnt <= '0;
      end else begin
         wd_cnt <= wd_cnt + 1'b1;
      end
   end

   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign head  = mem[rd_ptr[AW-1:0]];

   assign data_rd = bus.cs && !bus.we && !bus.addr;
   assign stat_rd = bus.cs && !bus.we &&  bus.addr;
   assign ctrl_wr = bus.cs &&  bus.we &&  bus.addr;
   assign flush   = ctrl_wr && bus.wdata[0];

   // A pop frees the head slot on the same edge, so a push into a full queue may reuse it.
   assign pop     = data_rd && !empty;
   assign do_push = push_req && !flush && (!full || pop);
   assign ovf_set = push_req && !flush && full && !pop;

   assign status  = {head[9] & ~empty, head[8] & ~empty, 3'b000, irq_en, overflow, ~empty};

   assign ctrl_unused = ^{bus.wdata[7:3], bus.wdata[1]};

   always_ff @(posedge clk) begin
      if (do_push)
         mem[wr_ptr[AW-1:0]] <= push_ev;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         overflow  <= 1'b0;
         irq_en    <= 1'b0;
         bus.irq   <= 1'b0;
         bus.rdata <= 8'h00;
      end else begin
         if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
         end else begin
            if (do_push)
               wr_ptr <= wr_ptr + 1'b1;
            if (pop)
               rd_ptr <= rd_ptr + 1'b1;
         end

         if (ovf_set)
            overflow <= 1'b1;
         else if (stat_rd)
            overflow <= 1'b0;

         if (ctrl_wr)
            irq_en <= bus.wdata[2];

         bus.irq <= irq_en && !empty;

         if (data_rd)
            bus.rdata <= empty ? 8'h00 : head[7:0];
         else if (stat_rd)
            bus.rdata <= status;
      end
   end

endmodule

// File: tb/tb_ps2_kbd_ctrl.sv
// Directed bench for ps2_kbd_ctrl: scan-code sequences, overflow, full-queue push/pop,
// watchdog expiry, interrupt/flush and mid-sequence reset, with hand-computed expectations.
module tb_ps2_kbd_ctrl;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   checks = 0;
   int   failures = 0;
   logic [7:0] d;

   ps2_kbd_ctrl_if bus ();

   ps2_kbd_ctrl #(
      .FIFO_DEPTH     (4),
      .TIMEOUT_CYCLES (8)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%02h exp=%02h", tag, got, exp);
      end else begin
         $display("ok   %s got=%02h", tag, got);
      end
   endtask

   // All tasks start and end on a falling edge; the DUT samples on the rising edge between.
   task automatic send_byte(input logic [7:0] b);
      bus.rx_valid = 1'b1;
      bus.rx_data  = b;
      @(negedge clk);
      bus.rx_valid = 1'b0;
   endtask

   task automatic bus_rd(input logic a, output logic [7:0] q);
      bus.cs   = 1'b1;
      bus.we   = 1'b0;
      bus.addr = a;
      @(negedge clk);
      bus.cs   = 1'b0;
      q        = bus.rdata;
   endtask

   task automatic bus_wr(input logic a, input logic [7:0] v);
      bus.cs    = 1'b1;
      bus.we    = 1'b1;
      bus.addr  = a;
      bus.wdata = v;
      @(negedge clk);
      bus.cs    = 1'b0;
      bus.we    = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic expect_event(input string tag, input logic [7:0] st, input logic [7:0] code);
      logic [7:0] q;
      bus_rd(1'b1, q);
      check({tag, "_status"}, q, st);
      bus_rd(1'b0, q);
      check({tag, "_data"}, q, code);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout got=running exp=finished");
      $fatal(1, "timeout");
   end

   initial begin
      logic [7:0] seq1 [7];
      logic [7:0] st1 [4];
      logic [7:0] cd1 [4];
      seq1 = '{8'h1C, 8'hE0, 8'h75, 8'hF0, 8'h1C, 8'hE0, 8'hF0};
      st1  = '{8'h01, 8'h81, 8'h41, 8'hC1};
      cd1  = '{8'h1C, 8'h75, 8'h1C, 8'h75};

      bus.rx_valid = 1'b0;
      bus.rx_data  = 8'h00;
      bus.cs       = 1'b0;
      bus.we       = 1'b0;
      bus.addr     = 1'b0;
      bus.wdata    = 8'h00;
      idle(3);
      reset = 1'b0;
      idle(1);

      check("rst_rdata", bus.rdata, 8'h00);
      check("rst_irq", {7'b0, bus.irq}, 8'h00);
      bus_rd(1'b1, d);
      check("rst_status", d, 8'h00);

      // Make and break codes, plain and extended.
      for (int i = 0; i < 7; i++)
         send_byte(seq1[i]);
      send_byte(8'h75);
      for (int i = 0; i < 4; i++)
         expect_event($sformatf("ev%0d", i + 1), st1[i], cd1[i]);

      // Five pushes into a depth-4 queue.
      for (int i = 0; i < 5; i++)
         send_byte(8'h11 + 8'(i));
      bus_rd(1'b1, d);
      check("ovf_status", d, 8'h03);
      bus_rd(1'b1, d);
      check("ovf_cleared", d, 8'h01);
      for (int i = 0; i < 4; i++) begin
         bus_rd(1'b0, d);
         check($sformatf("ovf_data%0d", i), d, 8'h11 + 8'(i));
      end
      bus_rd(1'b0, d);
      check("ovf_empty_data", d, 8'h00);

      // Push and pop on the same edge with the queue full.
      for (int i = 0; i < 4; i++)
         send_byte(8'h21 + 8'(i));
      bus.rx_valid = 1'b1;
      bus.rx_data  = 8'h25;
      bus_rd(1'b0, d);
      bus.rx_valid = 1'b0;
      check("full_pp_data", d, 8'h21);
      bus_rd(1'b1, d);
      check("full_pp_status", d, 8'h01);
      for (int i = 0; i < 4; i++) begin
         bus_rd(1'b0, d);
         check($sformatf("full_pp_q%0d", i), d, 8'h22 + 8'(i));
      end
      bus_rd(1'b1, d);
      check("full_pp_empty", d, 8'h00);

      // Watchdog: 8 idle cycles expire the E0 prefix, 6 do not.
      send_byte(8'hE0);
      idle(8);
      send_byte(8'h1C);
      expect_event("wd_expired", 8'h01, 8'h1C);
      send_byte(8'hE0);
      idle(6);
      send_byte(8'h1C);
      expect_event("wd_held", 8'h81, 8'h1C);

      // Interrupt enable, lag and flush.
      bus_wr(1'b1, 8'h04);
      idle(1);
      check("irq_empty", {7'b0, bus.irq}, 8'h00);
      send_byte(8'h1C);
      check("irq_lag", {7'b0, bus.irq}, 8'h00);
      idle(1);
      check("irq_rise", {7'b0, bus.irq}, 8'h01);
      bus_wr(1'b1, 8'h05);
      idle(1);
      check("irq_flush", {7'b0, bus.irq}, 8'h00);
      bus_rd(1'b1, d);
      check("flush_status", d, 8'h04);
      bus_rd(1'b0, d);
      check("flush_data", d, 8'h00);

      // Reset with two events queued and a half-received E0 F0 prefix.
      send_byte(8'h31);
      send_byte(8'h32);
      idle(1);
      check("pre_rst_irq", {7'b0, bus.irq}, 8'h01);
      send_byte(8'hE0);
      send_byte(8'hF0);
      reset = 1'b1;
      idle(1);
      reset = 1'b0;
      idle(1);
      check("mid_rst_irq", {7'b0, bus.irq}, 8'h00);
      check("mid_rst_rdata", bus.rdata, 8'h00);
      bus_rd(1'b1, d);
      check("mid_rst_status", d, 8'h00);
      send_byte(8'h1C);
      expect_event("post_rst", 8'h01, 8'h1C);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
